// File: rtl/m3_step_seq.sv
// rtl/m3_step_seq.sv - Commutation-step sequencer: bidirectional stepping, speed/power trim, timed brake
module m3_step_seq #(
    parameter int unsigned STEPS       = 12,
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned PERIOD_MAX  = 'h3FFFFF,
    parameter int unsigned PERIOD_MIN  = 2,
    parameter int unsigned SPEED_SHIFT = 3,
    parameter int unsigned ARM_LEN     = 16,
    parameter int unsigned BRAKE_LEN   = 64,
    parameter int unsigned POWER_W     = 8,
    localparam int unsigned SW         = $clog2(STEPS)
) (
    input  logic               clkI,
    input  logic               rstI,
    input  logic               startI,
    input  logic               forceStopI,
    input  logic               invRotateI,
    input  logic               speedINCi,
    input  logic               speedDECi,
    input  logic               powerINCi,
    input  logic               powerDECi,
    input  logic [CNT_W-1:0]   dstRoundLenI,
    output logic [SW-1:0]      stepO,
    output logic               stepStrobeO,
    output logic               roundDoneO,
    output logic [CNT_W-1:0]   periodO,
    output logic [POWER_W-1:0] powerO,
    output logic               workingO,
    output logic               brakingO
);

    localparam logic [CNT_W-1:0]   P_MAX     = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]   P_MIN     = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0]   ARM_CNT   = CNT_W'(ARM_LEN);
    localparam logic [CNT_W-1:0]   BRAKE_CNT = CNT_W'(BRAKE_LEN);
    localparam logic [CNT_W-1:0]   ONE       = CNT_W'(1);
    localparam logic [SW-1:0]      STEP_LAST = SW'(STEPS - 1);
    localparam logic [POWER_W-1:0] PWR_FULL  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN, ST_BRAKE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [POWER_W-1:0] power_q, power_d;
    logic [POWER_W-1:0] power_out_q, power_out_d;
    logic               strobe_q, strobe_d;
    logic               round_done_q, round_done_d;
    logic               working_q, working_d;
    logic               braking_q, braking_d;
    // bit order: speed inc, speed dec, power inc, power dec
    logic [3:0]         trim_sync_q, trim_sync_d;
    logic [3:0]         trim_hist_q, trim_hist_d;
    logic [3:0]         trim_rise;

    logic [CNT_W-1:0]   delta;
    logic [CNT_W:0]     period_dn, period_up;
    logic [CNT_W-1:0]   period_fast, period_slow, period_req;
    logic [SW-1:0]      step_next;
    logic               step_wrap;

    always_comb begin
        delta = period_q >> SPEED_SHIFT;
        if (delta == '0) begin
            delta = ONE;
        end
        period_dn   = {1'b0, period_q} - {1'b0, delta};
        period_up   = {1'b0, period_q} + {1'b0, delta};
        period_fast = (period_dn < {1'b0, P_MIN}) ? P_MIN : period_dn[CNT_W-1:0];
        period_slow = (period_up > {1'b0, P_MAX}) ? P_MAX : period_up[CNT_W-1:0];
        if (dstRoundLenI < P_MIN) begin
            period_req = P_MIN;
        end else if (dstRoundLenI > P_MAX) begin
            period_req = P_MAX;
        end else begin
            period_req = dstRoundLenI;
        end

        if (invRotateI) begin
            step_wrap = (step_q == '0);
            step_next = step_wrap ? STEP_LAST : step_q - SW'(1);
        end else begin
            step_wrap = (step_q == STEP_LAST);
            step_next = step_wrap ? '0 : step_q + SW'(1);
        end
    end

    always_comb begin
        trim_sync_d  = {powerDECi, powerINCi, speedDECi, speedINCi};
        trim_hist_d  = trim_sync_q;
        trim_rise    = trim_sync_q & ~trim_hist_q;
        state_d      = state_q;
        step_d       = step_q;
        period_d     = period_q;
        remain_d     = remain_q;
        power_d      = power_q;
        strobe_d     = 1'b0;
        round_done_d = 1'b0;

        if (trim_rise[2] && !trim_rise[3] && power_q != PWR_FULL) begin
            power_d = power_q + POWER_W'(1);
        end else if (trim_rise[3] && !trim_rise[2] && power_q != '0) begin
            power_d = power_q - POWER_W'(1);
        end

        // Trim only touches the stored period; the running slice keeps its reload value.
        if (state_q == ST_ARM || state_q == ST_RUN) begin
            if (trim_rise[0] && !trim_rise[1]) begin
                period_d = period_fast;
            end else if (trim_rise[1] && !trim_rise[0]) begin
                period_d = period_slow;
            end
        end

        if (forceStopI) begin
            if (state_q != ST_BRAKE) begin
                state_d  = ST_BRAKE;
                remain_d = BRAKE_CNT;
            end else if (remain_q > ONE) begin
                remain_d = remain_q - ONE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startI) begin
                        state_d  = ST_ARM;
                        period_d = period_req;
                        remain_d = ARM_CNT;
                    end
                end
                ST_ARM, ST_RUN: begin
                    if (!startI) begin
                        state_d  = ST_IDLE;
                        remain_d = P_MAX;
                    end else if (remain_q == ONE) begin
                        state_d  = ST_RUN;
                        remain_d = period_q;
                        strobe_d = 1'b1;
                        if (state_q == ST_ARM) begin
                            step_d = invRotateI ? STEP_LAST : '0;
                        end else begin
                            step_d       = step_next;
                            round_done_d = step_wrap;
                        end
                    end else begin
                        remain_d = remain_q - ONE;
                    end
                end
                ST_BRAKE: begin
                    if (remain_q > ONE) begin
                        remain_d = remain_q - ONE;
                    end else begin
                        state_d  = ST_IDLE;
                        remain_d = P_MAX;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        working_d   = (state_d == ST_ARM) || (state_d == ST_RUN);
        braking_d   = (state_d == ST_BRAKE);
        power_out_d = (state_d == ST_RUN) ? power_d : '0;
    end

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            period_q     <= P_MAX;
            remain_q     <= P_MAX;
            power_q      <= '0;
            power_out_q  <= '0;
            strobe_q     <= 1'b0;
            round_done_q <= 1'b0;
            working_q    <= 1'b0;
            braking_q    <= 1'b0;
            trim_sync_q  <= '0;
            trim_hist_q  <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            period_q     <= period_d;
            remain_q     <= remain_d;
            power_q      <= power_d;
            power_out_q  <= power_out_d;
            strobe_q     <= strobe_d;
            round_done_q <= round_done_d;
            working_q    <= working_d;
            braking_q    <= braking_d;
            trim_sync_q  <= trim_sync_d;
            trim_hist_q  <= trim_hist_d;
        end
    end

    assign stepO       = step_q;
    assign stepStrobeO = strobe_q;
    assign roundDoneO  = round_done_q;
    assign periodO     = period_q;
    assign powerO      = power_out_q;
    assign workingO    = working_q;
    assign brakingO    = braking_q;

endmodule

// File: tb/tb_m3_step_seq.sv
// tb/tb_m3_step_seq.sv - Self-checking bench for m3_step_seq with a cycle-level reference model
module tb_m3_step_seq;

    localparam int STEPS = 6;
    localparam int P_MAX = 200;
    localparam int P_MIN = 4;
    localparam int ARM_LEN = 16;
    localparam int BRAKE_LEN = 8;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_BRAKE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, force_stop, inv, sinc, sdec, pinc, pdec;
    logic [7:0] dst;
    logic [2:0] stepO;
    logic       stepStrobeO, roundDoneO, workingO, brakingO;
    logic [7:0] periodO, powerO;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    m3_step_seq #(
        .STEPS(6), .CNT_W(8), .PERIOD_MAX(200), .PERIOD_MIN(4), .SPEED_SHIFT(2),
        .ARM_LEN(16), .BRAKE_LEN(8), .POWER_W(8)
    ) dut (
        .clkI(clk), .rstI(rst), .startI(start), .forceStopI(force_stop), .invRotateI(inv),
        .speedINCi(sinc), .speedDECi(sdec), .powerINCi(pinc), .powerDECi(pdec),
        .dstRoundLenI(dst), .stepO(stepO), .stepStrobeO(stepStrobeO), .roundDoneO(roundDoneO),
        .periodO(periodO), .powerO(powerO), .workingO(workingO), .brakingO(brakingO)
    );

    // Reference model: slices are measured by elapsed cycles, brake by time since entry.
    int         m_mode, m_step, m_period, m_power, m_age, m_len;
    bit         m_strobe, m_round;
    logic [3:0] m_last, m_pend;

    task automatic model_reset();
        m_mode = M_IDLE; m_step = 0; m_period = P_MAX; m_power = 0;
        m_age = 0; m_len = 0; m_strobe = 0; m_round = 0; m_last = '0; m_pend = '0;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step();
        int old_period, old_mode, d;
        logic [3:0] fire, now_in;
        if (rst) begin
            model_reset();
            return;
        end
        old_period = m_period;
        old_mode = m_mode;
        fire = m_pend;
        now_in = {pdec, pinc, sdec, sinc};
        m_pend = now_in & ~m_last;
        m_last = now_in;
        m_strobe = 0;
        m_round = 0;
        if (fire[2] != fire[3]) m_power = clamp(m_power + (fire[2] ? 1 : -1), 0, 255);
        if ((old_mode == M_ARM || old_mode == M_RUN) && fire[0] != fire[1]) begin
            d = old_period / 4;
            if (d < 1) d = 1;
            m_period = clamp(fire[0] ? old_period - d : old_period + d, P_MIN, P_MAX);
        end
        if (force_stop) begin
            if (old_mode == M_BRAKE) m_age++;
            else begin m_mode = M_BRAKE; m_age = 0; end
        end else if (old_mode == M_IDLE) begin
            if (start) begin
                m_mode = M_ARM; m_age = 0; m_len = ARM_LEN;
                m_period = clamp(int'(dst), P_MIN, P_MAX);
            end
        end else if (old_mode == M_BRAKE) begin
            m_age++;
            if (m_age >= BRAKE_LEN) m_mode = M_IDLE;
        end else if (!start) begin
            m_mode = M_IDLE;
        end else begin
            m_age++;
            if (m_age == m_len) begin
                if (old_mode == M_ARM) begin
                    m_mode = M_RUN;
                    m_step = inv ? STEPS - 1 : 0;
                end else begin
                    m_step = inv ? (m_step + STEPS - 1) % STEPS : (m_step + 1) % STEPS;
                    m_round = (m_step == (inv ? STEPS - 1 : 0));
                end
                m_strobe = 1; m_age = 0; m_len = old_period;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [2:0] e_step;
        logic [7:0] e_per, e_pwr;
        logic       e_wk, e_bk;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e_step = 3'(m_step);
        e_per = 8'(m_period);
        e_pwr = (m_mode == M_RUN) ? 8'(m_power) : 8'd0;
        e_wk = (m_mode == M_ARM || m_mode == M_RUN);
        e_bk = (m_mode == M_BRAKE);
        total++;
        if (stepO !== e_step || stepStrobeO !== m_strobe || roundDoneO !== m_round ||
            periodO !== e_per || powerO !== e_pwr || workingO !== e_wk || brakingO !== e_bk) begin
            bad++;
            $display("FAIL model t=%0t got step=%0d stb=%0d rd=%0d per=%0d pwr=%0d wk=%0d bk=%0d want step=%0d stb=%0d rd=%0d per=%0d pwr=%0d wk=%0d bk=%0d",
                     $time, stepO, stepStrobeO, roundDoneO, periodO, powerO, workingO, brakingO,
                     e_step, m_strobe, m_round, e_per, e_pwr, e_wk, e_bk);
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (stepStrobeO !== 1'b1 && n < limit);
        check("strobe_seen", 32'(stepStrobeO), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"}, 32'(stepO), 32'd0);
        check({tag, "_period"}, 32'(periodO), 32'd200);
        check({tag, "_strobe"}, 32'(stepStrobeO), 32'd0);
        check({tag, "_round"}, 32'(roundDoneO), 32'd0);
        check({tag, "_power"}, 32'(powerO), 32'd0);
        check({tag, "_working"}, 32'(workingO), 32'd0);
        check({tag, "_braking"}, 32'(brakingO), 32'd0);
    endtask

    typedef struct {
        int dst;
        bit inc;
        bit dec;
        int load;
        int want;
    } trim_vec_t;

    trim_vec_t vecs[13];

    initial begin
        int n, cnt, g, s;
        int fwd_steps[6];
        int rev_steps[6];
        vecs[0]  = '{100, 1'b1, 1'b0, 100, 75};
        vecs[1]  = '{190, 1'b0, 1'b1, 190, 200};
        vecs[2]  = '{100, 1'b1, 1'b1, 100, 100};
        vecs[3]  = '{1,   1'b0, 1'b0, 4,   4};
        vecs[4]  = '{250, 1'b0, 1'b0, 200, 200};
        vecs[5]  = '{4,   1'b1, 1'b0, 4,   4};
        vecs[6]  = '{10,  1'b1, 1'b0, 10,  8};
        vecs[7]  = '{7,   1'b0, 1'b1, 7,   8};
        vecs[8]  = '{200, 1'b0, 1'b1, 200, 200};
        vecs[9]  = '{0,   1'b0, 1'b1, 4,   5};
        vecs[10] = '{5,   1'b1, 1'b0, 5,   4};
        vecs[11] = '{160, 1'b0, 1'b1, 160, 200};
        vecs[12] = '{3,   1'b0, 1'b0, 4,   4};
        fwd_steps = '{1, 2, 3, 4, 5, 0};
        rev_steps = '{4, 3, 2, 1, 0, 5};

        rst = 1; start = 0; force_stop = 0; inv = 0;
        sinc = 0; sdec = 0; pinc = 0; pdec = 0; dst = 0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 0;
        tick();

        foreach (vecs[i]) begin
            start = 0;
            tick();
            dst = 8'(vecs[i].dst);
            start = 1;
            tick();
            check("tbl_load", 32'(periodO), 32'(vecs[i].load));
            sinc = vecs[i].inc;
            sdec = vecs[i].dec;
            tick();
            sinc = 0;
            sdec = 0;
            tick();
            check("tbl_trim", 32'(periodO), 32'(vecs[i].want));
        end
        start = 0;
        tick();

        // Forward run at period 10
        inv = 0; dst = 10; start = 1;
        tick();
        check("fwd_working", 32'(workingO), 32'd1);
        wait_strobe(40, n);
        check("fwd_first_gap", 32'(n), 32'd16);
        check("fwd_first_step", 32'(stepO), 32'd0);
        for (int k = 0; k < 6; k++) begin
            wait_strobe(30, n);
            check("fwd_gap", 32'(n), 32'd10);
            check("fwd_step", 32'(stepO), 32'(fwd_steps[k]));
            check("fwd_round", 32'(roundDoneO), 32'(k == 5));
        end

        // Speed trim mid-slice: current slice keeps its old length
        start = 0;
        tick();
        dst = 100; start = 1;
        tick();
        wait_strobe(40, n);
        sinc = 1;
        tick();
        sinc = 0;
        tick();
        check("spd_period", 32'(periodO), 32'd75);
        wait_strobe(200, n);
        check("spd_old_slice", 32'(n), 32'd98);
        wait_strobe(200, n);
        check("spd_new_slice", 32'(n), 32'd75);

        // Reverse with period clamp
        start = 0;
        tick();
        check("rev_idle", 32'(workingO), 32'd0);
        inv = 1; dst = 1; start = 1;
        tick();
        check("rev_period", 32'(periodO), 32'd4);
        wait_strobe(40, n);
        check("rev_first_gap", 32'(n), 32'd16);
        check("rev_first_step", 32'(stepO), 32'd5);
        for (int k = 0; k < 6; k++) begin
            wait_strobe(30, n);
            check("rev_gap", 32'(n), 32'd4);
            check("rev_step", 32'(stepO), 32'(rev_steps[k]));
            check("rev_round", 32'(roundDoneO), 32'(k == 5));
        end

        // Start drop mid-slice
        wait_strobe(20, n);
        s = int'(stepO);
        tick();
        tick();
        start = 0;
        tick();
        check("drop_working", 32'(workingO), 32'd0);
        check("drop_step", 32'(stepO), 32'(s));
        cnt = 0;
        repeat (10) begin
            tick();
            if (stepStrobeO) cnt++;
        end
        check("drop_no_strobe", 32'(cnt), 32'd0);

        // Power trim: accepted in IDLE, visible only in RUN, saturates at 0
        inv = 0;
        repeat (3) begin
            pinc = 1;
            tick();
            pinc = 0;
            tick();
            check("pwr_idle", 32'(powerO), 32'd0);
        end
        dst = 6; start = 1;
        tick();
        check("pwr_arm", 32'(powerO), 32'd0);
        wait_strobe(40, n);
        check("pwr_run", 32'(powerO), 32'd3);
        repeat (4) begin
            pdec = 1;
            tick();
            pdec = 0;
            tick();
        end
        check("pwr_dec_sat", 32'(powerO), 32'd0);
        repeat (2) begin
            pinc = 1;
            tick();
            pinc = 0;
            tick();
        end
        check("pwr_inc", 32'(powerO), 32'd2);

        // Asynchronous reset during RUN
        tick();
        #2 rst = 1;
        #1 check_reset_outputs("async_rst");
        start = 0;
        tick();
        rst = 0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (stepStrobeO) cnt++;
        end
        check("rst_no_strobe", 32'(cnt), 32'd0);
        check("rst_idle", 32'(workingO), 32'd0);

        // Force stop held 3 cycles in RUN
        pinc = 1;
        tick();
        pinc = 0;
        tick();
        dst = 10; start = 1;
        tick();
        wait_strobe(40, n);
        check("brk_pre_power", 32'(powerO), 32'd1);
        force_stop = 1;
        tick();
        check("brk_braking", 32'(brakingO), 32'd1);
        check("brk_working", 32'(workingO), 32'd0);
        check("brk_power", 32'(powerO), 32'd0);
        tick();
        tick();
        force_stop = 0;
        cnt = 3;
        g = 0;
        while (brakingO && g < 40) begin
            tick();
            g++;
            if (brakingO) cnt++;
        end
        check("brk_len", 32'(cnt), 32'd8);
        check("brk_idle", 32'(workingO), 32'd0);
        tick();
        check("brk_rearm", 32'(workingO), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (start) start = ($urandom_range(0, 99) >= 1);
            else start = ($urandom_range(0, 9) == 0);
            force_stop = ($urandom_range(0, 99) < 2) || (force_stop && $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) inv = ~inv;
            sinc = ($urandom_range(0, 9) == 0);
            sdec = ($urandom_range(0, 9) == 0);
            pinc = ($urandom_range(0, 7) == 0);
            pdec = ($urandom_range(0, 9) == 0);
            dst = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 0; start = 0; force_stop = 0; sinc = 0; sdec = 0; pinc = 0; pdec = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m3_step_seq.md
# m3_step_seq

Parametrised commutation-step sequencer for the three-phase motor drive. It generalises the fixed 12-step slice counter to a configurable step count and counter width. It adds bidirectional stepping, run-time speed and power trim, and a timed brake state. It sits between the command decoder (start/stop/inc/dec pulses) and the phase-drive PWM stage, which consumes `stepO`, `stepStrobeO` and `powerO`.

## Interface
- `STEPS`, 12: steps per electrical round (≥2); `SW = $clog2(STEPS)`.
- `CNT_W`, 22: width of the slice counter and period.
- `PERIOD_MAX`, 22'h3FFFFF: slowest slice length (cycles).
- `PERIOD_MIN`, 2: fastest slice length (≥2).
- `SPEED_SHIFT`, 3: speed trim granularity, delta = period >> SPEED_SHIFT (min 1).
- `ARM_LEN`, 16: cycles in ARM before first step.
- `BRAKE_LEN`, 64: minimum cycles in BRAKE.
- `POWER_W`, 8: power level width.
- `clkI` in 1: clock, all logic on rising edge.
- `rstI` in 1: asynchronous, active-high reset.
- `startI` in 1: level; run while high.
- `forceStopI` in 1: level; immediate brake, overrides start.
- `invRotateI` in 1: 0 = step ascending, 1 = descending.
- `speedINCi` / `speedDECi` in 1: rising-edge-detected speed trim.
- `powerINCi` / `powerDECi` in 1: rising-edge-detected power trim.
- `dstRoundLenI` in CNT_W: requested slice period, sampled on IDLE→ARM.
- `stepO` out SW: current step index.
- `stepStrobeO` out 1: one-cycle pulse in the cycle `stepO` takes a new value.
- `roundDoneO` out 1: one-cycle pulse coincident with a wrap strobe.
- `periodO` out CNT_W: active slice period.
- `powerO` out POWER_W: power level; forced 0 outside RUN.
- `workingO` out 1: high in ARM or RUN.
- `brakingO` out 1: high in BRAKE.

## Operation
- States are IDLE, ARM, RUN and BRAKE.
- Reset values: state IDLE, `stepO`=0, `periodO`=PERIOD_MAX, power register 0, `remain`=PERIOD_MAX. All pulse outputs, `workingO`, `brakingO` and `powerO` are 0. Edge-detect history regs are 0.
- Priority each cycle: `forceStopI` > `!startI` > normal progress.
- IDLE → ARM when `startI` && !`forceStopI`:
  - `periodO` ← clamp(`dstRoundLenI`, PERIOD_MIN, PERIOD_MAX).
  - `remain` ← ARM_LEN.
- ARM: `remain` decrements. When `remain`==1, go to RUN and assert `stepStrobeO`. `stepO` ← 0 if `invRotateI`=0, else STEPS-1. `remain` ← `periodO`.
- RUN: `remain` decrements. When `remain`==1:
  - `stepO` advances: +1 wrapping STEPS-1→0, or −1 wrapping 0→STEPS-1 if `invRotateI`.
  - `remain` ← `periodO` and `stepStrobeO` pulses.
  - `roundDoneO` pulses when the advance wraps.
  - Direction is sampled only at this boundary.
- `!startI` (not braking) in ARM/RUN → IDLE next cycle. `stepO` holds its value; `remain` ← PERIOD_MAX.
- `forceStopI` in any state → BRAKE with `remain` ← BRAKE_LEN. BRAKE counts down and stays while `forceStopI` is high or `remain`>1, then goes to IDLE.
- Speed trim applies in ARM/RUN only:
  - On a rising edge of `speedINCi`, `periodO` ← max(period − delta, PERIOD_MIN).
  - On a rising edge of `speedDECi`, `periodO` ← min(period + delta, PERIOD_MAX). The add is computed at CNT_W+1 bits before the clamp.
  - Rising edges of both in the same cycle: no change.
  - A new period takes effect at the next reload. The running slice is never truncated.
- Power trim: ±1 saturating at 0 / 2^POWER_W−1 on a rising edge of `powerINCi` / `powerDECi`. It is accepted in any state; both in the same cycle means no change. The register value is retained across stops. `powerO` = register value in RUN, else 0.

## Timing
- Edge detect adds 1 cycle: a trim input rising at edge N updates the register at edge N+1.
- `workingO` rises 1 cycle after `startI` is sampled high in IDLE.
- The first `stepStrobeO` comes ARM_LEN cycles after `workingO` rises. Subsequent strobes are exactly `periodO` cycles apart.
- `stepO`, `stepStrobeO` and `roundDoneO` are registered and change in the same cycle.
- `rstI` mid-operation forces all reset values asynchronously. After release, the block waits for `startI` in IDLE; no strobe is emitted on reset.

## Test plan
Setup for all scenarios: STEPS=6, CNT_W=8, PERIOD_MAX=200, PERIOD_MIN=4, ARM_LEN=16, BRAKE_LEN=8, SPEED_SHIFT=2.
- Forward run: `dstRoundLenI`=10, `startI`=1 → first strobe 16 cycles after `workingO` with `stepO`=0. Then `stepO` = 1..5,0 at 10-cycle spacing, and `roundDoneO` pulses with the 5→0 strobe.
- Reverse plus clamp: `invRotateI`=1, `dstRoundLenI`=1 → `periodO`=4, `stepO` sequence 5,4,3,2,1,0,5, `roundDoneO` on 0→5.
- Speed trim: period 100, one `speedINCi` pulse → 75. At period 190, `speedDECi` → 200 (saturated). Both pulsed together → unchanged. The current slice completes at its old length.
- Force stop: `forceStopI` held 3 cycles mid-RUN → BRAKE for 8 cycles total, `powerO`=0, `workingO`=0, then IDLE. `startI` held high throughout re-arms afterwards.
- Start drop plus reset: `startI`→0 mid-slice → IDLE next cycle, `stepO` held, no strobe. `rstI` pulse during RUN → all outputs at reset values immediately.
- Power: 3 `powerINCi` pulses in IDLE → `powerO`=0, then 3 when RUN is entered. 4 `powerDECi` pulses → 0 (saturated).
